// File: rtl/ifu_fetch_if.sv
// Fetch unit boundary: redirect input, imem request/response channel
// and the decode-side instruction output.
interface ifu_fetch_if;
   logic         redirect_valid;
   logic [63:0]  redirect_pc;
   logic         imem_req_valid;
   logic [63:0]  imem_req_addr;
   logic         imem_req_ready;
   logic         imem_resp_valid;
   logic [31:0]  imem_resp_data;
   logic         fetch_o_valid;
   logic [63:0]  fetch_o_pc;
   logic [31:0]  fetch_o_instr;
   logic [160:0] fetch_o_commit_info;
   logic         regD_allow_in;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      output fetch_o_valid,
      output fetch_o_pc,
      output fetch_o_instr,
      output fetch_o_commit_info,
      input  regD_allow_in
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      input  fetch_o_valid,
      input  fetch_o_pc,
      input  fetch_o_instr,
      input  fetch_o_commit_info,
      output regD_allow_in
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC generation, in-flight PC tracking with stale-response
// dropping, and a 2-deep output buffer toward the decode register.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input logic         clk,
   input logic         rst,
   ifu_fetch_if.master bus
);

   logic [63:0] pc_q, pc_d;
   logic [63:0] inf_pc_q [2];
   logic [63:0] inf_pc_d [2];
   logic        inf_head_q, inf_head_d;
   logic [1:0]  inf_cnt_q, inf_cnt_d;
   logic [63:0] buf_pc_q [2];
   logic [63:0] buf_pc_d [2];
   logic [31:0] buf_instr_q [2];
   logic [31:0] buf_instr_d [2];
   logic        buf_head_q, buf_head_d;
   logic [1:0]  buf_cnt_q, buf_cnt_d;
   logic [1:0]  drop_q, drop_d;

   logic        out_fire;
   logic        req_fire;
   logic        resp_good;
   logic [2:0]  occ;
   logic        inf_tail;
   logic        buf_tail;
   logic [63:0] head_pc;
   logic [31:0] head_instr;

   assign head_pc    = buf_pc_q[buf_head_q];
   assign head_instr = buf_instr_q[buf_head_q];
   assign inf_tail   = inf_head_q ^ inf_cnt_q[0];
   assign buf_tail   = buf_head_q ^ buf_cnt_q[0];

   assign bus.fetch_o_valid = (buf_cnt_q != 2'd0) && !bus.redirect_valid;
   assign bus.fetch_o_pc    = head_pc;
   assign bus.fetch_o_instr = head_instr;
   assign bus.fetch_o_commit_info = bus.fetch_o_valid ?
      {1'b1, head_pc, head_instr, head_pc + 64'd4} : '0;

   assign out_fire = bus.fetch_o_valid && bus.regD_allow_in;

   // Stale in-flight requests still hold a slot, so a good response
   // always finds room in the buffer.
   assign occ = {1'b0, inf_cnt_q} + {1'b0, buf_cnt_q} - {2'b00, out_fire};

   assign bus.imem_req_valid = !rst && !bus.redirect_valid && (occ < 3'd2);
   assign bus.imem_req_addr  = pc_q;
   assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

   assign resp_good = bus.imem_resp_valid && !bus.redirect_valid &&
                      (drop_q == 2'd0);

   always_comb begin
      pc_d        = pc_q;
      inf_pc_d    = inf_pc_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      inf_head_d  = inf_head_q ^ bus.imem_resp_valid;
      inf_cnt_d   = inf_cnt_q + {1'b0, req_fire}
                  - {1'b0, bus.imem_resp_valid};
      buf_head_d  = buf_head_q ^ out_fire;
      buf_cnt_d   = buf_cnt_q + {1'b0, resp_good} - {1'b0, out_fire};
      drop_d      = drop_q;

      if (req_fire) begin
         pc_d = pc_q + 64'd4;
         inf_pc_d[inf_tail] = pc_q;
      end

      if (resp_good) begin
         buf_pc_d[buf_tail]    = inf_pc_q[inf_head_q];
         buf_instr_d[buf_tail] = bus.imem_resp_data;
      end

      if (bus.redirect_valid) begin
         pc_d      = bus.redirect_pc & ~64'd3;
         buf_cnt_d = 2'd0;
         drop_d    = inf_cnt_q - {1'b0, bus.imem_resp_valid};
      end else if (bus.imem_resp_valid && (drop_q != 2'd0)) begin
         drop_d = drop_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inf_pc_q    <= '{default: '0};
         inf_head_q  <= 1'b0;
         inf_cnt_q   <= 2'd0;
         buf_pc_q    <= '{default: '0};
         buf_instr_q <= '{default: '0};
         buf_head_q  <= 1'b0;
         buf_cnt_q   <= 2'd0;
         drop_q      <= 2'd0;
      end else begin
         pc_q        <= pc_d;
         inf_pc_q    <= inf_pc_d;
         inf_head_q  <= inf_head_d;
         inf_cnt_q   <= inf_cnt_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_head_q  <= buf_head_d;
         buf_cnt_q   <= buf_cnt_d;
         drop_q      <= drop_d;
      end
   end

   a_resp_has_owner: assert property (@(posedge clk) disable iff (rst)
      bus.imem_resp_valid |-> (inf_cnt_q != 2'd0));

   a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
      resp_good |-> ((buf_cnt_q != 2'd2) || out_fire));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: in-order variable-latency memory plus
// a queue-based model of the expected request and instruction streams.
module tb_ifu_fetch;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] pc;
      int          epoch;
      int          ready_at;
   } mreq_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] data;
   } bent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   ifu_fetch_if bus ();

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks;
   int errors;
   int cyc;
   int epoch;
   logic [63:0] req_pc;
   mreq_t memq[$];
   bent_t bq[$];

   logic        c_rst;
   logic        c_redir;
   logic [63:0] c_rpc;
   logic        c_ready;
   logic        c_allow;
   int          c_lmin;
   int          c_lmax;

   function automatic logic [31:0] word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [160:0] act,
                      input logic [160:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // One clock: drive inputs, compare against the model, advance the model.
   task automatic cycle();
      logic  resp;
      logic  exp_v;
      logic  exp_rv;
      logic  fire;
      int    occ;
      mreq_t m;
      bent_t b;
      @(posedge clk);
      #1;
      cyc++;
      rst = c_rst;
      bus.redirect_valid = c_redir;
      bus.redirect_pc    = c_rpc;
      bus.imem_req_ready = c_ready;
      bus.regD_allow_in  = c_allow;
      resp = !c_rst && (memq.size() > 0) && (memq[0].ready_at <= cyc);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? word(memq[0].addr) : $urandom();
      #4;
      if (c_rst) begin
         chk("rst_req_valid", bus.imem_req_valid, 1'b0);
         chk("rst_req_addr", bus.imem_req_addr, RST_PC);
         chk("rst_fetch_valid", bus.fetch_o_valid, 1'b0);
         chk("rst_fetch_pc", bus.fetch_o_pc, 64'h0);
         chk("rst_commit", bus.fetch_o_commit_info, 161'h0);
         memq.delete();
         bq.delete();
         req_pc = RST_PC;
      end else begin
         exp_v  = (bq.size() > 0) && !c_redir;
         fire   = exp_v && c_allow;
         occ    = memq.size() + bq.size() - (fire ? 1 : 0);
         exp_rv = !c_redir && (occ < 2);
         chk("req_valid", bus.imem_req_valid, exp_rv);
         chk("req_addr", bus.imem_req_addr, req_pc);
         chk("fetch_valid", bus.fetch_o_valid, exp_v);
         if (exp_v) begin
            chk("fetch_pc", bus.fetch_o_pc, bq[0].pc);
            chk("fetch_instr", bus.fetch_o_instr, bq[0].data);
            chk("commit_info", bus.fetch_o_commit_info,
                {1'b1, bq[0].pc, bq[0].data, bq[0].pc + 64'd4});
         end
         if (fire) void'(bq.pop_front());
         if (resp) begin
            m = memq.pop_front();
            if (!c_redir && (m.epoch == epoch)) begin
               b.pc   = m.pc;
               b.data = word(m.addr);
               bq.push_back(b);
            end
         end
         if (c_redir) begin
            bq.delete();
            epoch++;
            req_pc = c_rpc & ~64'd3;
         end else if (exp_rv && c_ready) begin
            m.addr     = bus.imem_req_addr;
            m.pc       = req_pc;
            m.epoch    = epoch;
            m.ready_at = cyc + $urandom_range(c_lmax, c_lmin);
            memq.push_back(m);
            req_pc = req_pc + 64'd4;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic found;
      checks = 0;
      errors = 0;
      cyc    = 0;
      epoch  = 0;
      req_pc = RST_PC;
      c_rst = 1'b1; c_redir = 1'b0; c_rpc = 64'h0;
      c_ready = 1'b1; c_allow = 1'b1; c_lmin = 1; c_lmax = 1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 64'h0;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.regD_allow_in   = 1'b1;
      #1 rst = 1'b1;
      repeat (3) cycle();

      // Release with a 1-cycle memory: request N, response N+1, valid N+2.
      c_rst = 1'b0;
      cycle();
      chk("first_req_addr", bus.imem_req_addr, 64'h8000_0000);
      chk("first_req_valid", bus.imem_req_valid, 1'b1);
      cycle();
      chk("t1_fetch_valid", bus.fetch_o_valid, 1'b0);
      cycle();
      chk("t2_pc", bus.fetch_o_pc, 64'h8000_0000);
      chk("t2_commit_next", bus.fetch_o_commit_info[63:0], 64'h8000_0004);
      chk("t2_commit_v", bus.fetch_o_commit_info[160], 1'b1);
      cycle();
      chk("t3_pc", bus.fetch_o_pc, 64'h8000_0004);
      cycle();
      chk("t4_pc", bus.fetch_o_pc, 64'h8000_0008);

      // Decode stall: buffer fills, requests stop, head held.
      c_allow = 1'b0;
      repeat (5) cycle();
      chk("stall_req_valid", bus.imem_req_valid, 1'b0);
      chk("stall_valid", bus.fetch_o_valid, 1'b1);
      chk("stall_pc", bus.fetch_o_pc, 64'h8000_000C);
      c_allow = 1'b1;
      cycle();
      chk("resume_pc0", bus.fetch_o_pc, 64'h8000_000C);
      cycle();
      chk("resume_pc1", bus.fetch_o_pc, 64'h8000_0010);
      repeat (4) cycle();

      // Redirect with two requests in flight.
      c_lmin = 3; c_lmax = 3;
      for (int i = 0; i < 20 && memq.size() != 2; i++) cycle();
      if (memq.size() != 2) bound_fail("two_inflight");
      c_redir = 1'b1; c_rpc = 64'h8000_2000;
      cycle();
      c_redir = 1'b0;
      cycle();
      chk("redir_req_addr", bus.imem_req_addr, 64'h8000_2000);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.fetch_o_valid) begin
            found = 1'b1;
            break;
         end
         cycle();
      end
      if (found) chk("redir_first_pc", bus.fetch_o_pc, 64'h8000_2000);
      else bound_fail("redir_first_valid");
      repeat (6) cycle();

      // Misaligned redirect target, then memory not ready for 3 cycles.
      c_lmin = 1; c_lmax = 1;
      c_redir = 1'b1; c_rpc = 64'h8000_1002;
      cycle();
      c_redir = 1'b0;
      c_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("align_hold_addr", bus.imem_req_addr, 64'h8000_1000);
      end
      c_ready = 1'b1;
      repeat (10) cycle();

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         c_ready = ($urandom_range(0, 99) < 70);
         c_allow = ($urandom_range(0, 99) < 70);
         c_redir = ($urandom_range(0, 99) < 4);
         c_rpc   = {32'h0, $urandom()};
         c_lmin  = 1;
         c_lmax  = 4;
         cycle();
      end

      // Reset asserted between edges in the middle of a stream.
      c_redir = 1'b0; c_ready = 1'b1; c_allow = 1'b1;
      c_lmin = 1; c_lmax = 1;
      repeat (10) cycle();
      #2;
      rst = 1'b1;
      bus.imem_resp_valid = 1'b0;
      #1;
      chk("mid_rst_req_valid", bus.imem_req_valid, 1'b0);
      chk("mid_rst_fetch_valid", bus.fetch_o_valid, 1'b0);
      chk("mid_rst_pc", bus.fetch_o_pc, 64'h0);
      chk("mid_rst_instr", bus.fetch_o_instr, 32'h0);
      chk("mid_rst_commit", bus.fetch_o_commit_info, 161'h0);
      chk("mid_rst_req_addr", bus.imem_req_addr, RST_PC);
      memq.delete();
      bq.delete();
      req_pc = RST_PC;
      c_rst = 1'b1;
      repeat (2) cycle();
      c_rst = 1'b0;
      cycle();
      chk("restart_req_addr", bus.imem_req_addr, 64'h8000_0000);
      chk("restart_req_valid", bus.imem_req_valid, 1'b1);
      cycle();
      cycle();
      chk("restart_pc", bus.fetch_o_pc, 64'h8000_0000);
      repeat (20) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 redirect_valid  input  1  branch/exception redirect request from a later stage.
REQ-005 redirect_pc  input  64  redirect target address.
REQ-006 imem_req_valid  output  1  instruction memory request valid.
REQ-007 imem_req_addr  output  64  request address, bits [1:0] always 0.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance.
REQ-010 imem_resp_data  input  32  instruction word.
REQ-011 fetch_o_valid  output  1  fetched instruction valid toward the decode register.
REQ-012 fetch_o_pc  output  64  PC of the presented instruction.
REQ-013 fetch_o_instr  output  32  presented instruction.
REQ-014 fetch_o_commit_info  output  161  {1'b1, pc[63:0], instr[31:0], pc+4[63:0]}, bit 160 = 1 when valid.
REQ-015 regD_allow_in  input  1  decode register accepts this cycle.

Function
REQ-016 Fetch PC register advances by 4 on each accepted request (imem_req_valid && imem_req_ready); no compressed instructions.
REQ-017 In-flight PC queue, depth 2, records the address of each accepted request; popped on each imem_resp_valid.
REQ-018 Output buffer, depth 2, FIFO of {pc, instr}; head drives fetch_o_pc/instr/commit_info.
REQ-019 imem_req_valid = !rst && !redirect_valid && (inflight + buf_count - out_fire) < 2; out_fire = fetch_o_valid && regD_allow_in.
REQ-020 imem_req_addr and PC held stable while imem_req_valid && !imem_req_ready.
REQ-021 fetch_o_valid = buffer non-empty && !redirect_valid && drop_cnt irrelevant (buffer only holds good-path entries).
REQ-022 Transfer occurs only on out_fire; while fetch_o_valid && !regD_allow_in, all fetch_o_* held stable.
REQ-023 Response with drop_cnt == 0: {queue head PC, imem_resp_data} written to buffer end of cycle; same-cycle enqueue and dequeue both allowed.
REQ-024 Response with drop_cnt > 0: discarded, drop_cnt decremented, queue popped.
REQ-025 Redirect cycle: PC <= {redirect_pc[63:2], 2'b00}; buffer flushed; no request issued; any response that cycle discarded; drop_cnt <= inflight - imem_resp_valid.
REQ-026 Redirect while drop_cnt > 0: same rule, drop_cnt recomputed from current inflight.
REQ-027 Requests may issue while drop_cnt > 0; credit counts stale in-flight requests.
REQ-028 Latency with 1-cycle memory: request cycle N, response N+1, fetch_o_valid N+2; steady state one instruction per cycle.
REQ-029 Buffer never overflows; response while buffer full is impossible by REQ-019 and flagged by assertion.

Reset
REQ-030 On rst assertion, immediately: PC = RESET_PC, queue and buffer empty, inflight = 0, drop_cnt = 0, imem_req_valid = 0, fetch_o_valid = 0, fetch_o_pc/instr/commit_info = 0.
REQ-031 Reset mid-operation discards all in-flight and buffered instructions; the bench suppresses memory responses to pre-reset requests.
REQ-032 First request (addr RESET_PC) in first cycle after rst deasserts.

Verification
REQ-033 Reset release, ready=1, 1-cycle memory, allow_in=1 -> fetch_o_pc 0x80000000 at cycle 2, then 0x80000004, 0x80000008 on consecutive cycles; commit_info[63:0] = pc+4.
REQ-034 allow_in=0 for 5 cycles -> buffer reaches 2, imem_req_valid=0, fetch_o_* constant; release -> sequence resumes, no loss or duplicate.
REQ-035 Redirect to 0x80002000 with 2 requests in flight -> next 2 responses dropped, first fetch_o_pc = 0x80002000.
REQ-036 redirect_pc = 0x80001002 -> next imem_req_addr = 0x80001000.
REQ-037 imem_req_ready=0 for 3 cycles -> imem_req_addr constant, PC unchanged, no fetch_o_valid gap beyond buffer drain.
REQ-038 rst asserted mid-stream between clock edges -> fetch_o_valid and imem_req_valid 0 immediately; after release, fetch restarts at RESET_PC.
